// File: rtl/red_light_monitor.sv
// Receive-side checker for the R/Y/G/W lamp interface: tracks GREEN->YELLOW->RED dwell, reports faults/red runs.
// Optional VIOL_TIMESTAMP_EN adds viol_time, the tick count captured when an event loads.
module red_light_monitor #(
    parameter int G_TICKS = 4,
    parameter int Y_TICKS = 1,
    parameter int R_TICKS = 6,
    parameter int CNT_W   = 8
) (
    input  logic             clk_1,
    input  logic             reset,
    input  logic             r_in,
    input  logic             y_in,
    input  logic             g_in,
    input  logic             w_in,
    input  logic             car_cross,
    input  logic             viol_ack,
    output logic             viol_valid,
    output logic [2:0]       viol_code,
    output logic [CNT_W-1:0] red_run_cnt,
    output logic [CNT_W-1:0] seq_err_cnt,
    output logic [1:0]       phase,
`ifdef VIOL_TIMESTAMP_EN
    output logic [15:0]      viol_time,
`endif
    output logic             locked
);

    localparam int MAXL = (G_TICKS > Y_TICKS) ? ((G_TICKS > R_TICKS) ? G_TICKS : R_TICKS)
                                              : ((Y_TICKS > R_TICKS) ? Y_TICKS : R_TICKS);
    localparam int DW = (MAXL < 1) ? 1 : $clog2(MAXL + 1);
    localparam logic [DW-1:0] G_LIM = DW'(G_TICKS);
    localparam logic [DW-1:0] Y_LIM = DW'(Y_TICKS);
    localparam logic [DW-1:0] R_LIM = DW'(R_TICKS);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_RED    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE      = 3'd0,
        EV_ILLEGAL   = 3'd1,
        EV_EARLY     = 3'd2,
        EV_LATE      = 3'd3,
        EV_BAD_ORDER = 3'd4,
        EV_RED_RUN   = 3'd5
    } ev_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic              prev_red_q, prev_red_d;
    logic [CNT_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0]  se_q, se_d;
    logic              valid_q, valid_d;
    ev_t               code_q, code_d;

    state_t            pat_st;
    state_t            succ;
    logic [DW-1:0]     limit;
    ev_t               seq_ev;
    ev_t               new_ev;
    logic              red_run;

    // Decoded lamp pattern expressed as a phase; ST_SYNC stands for an illegal pattern.
    always_comb begin
        pat_st = ST_SYNC;
        case ({r_in, y_in, g_in, w_in})
            4'b0010:          pat_st = ST_GREEN;
            4'b0100:          pat_st = ST_YELLOW;
            4'b1000, 4'b1001: pat_st = ST_RED;
            default:          pat_st = ST_SYNC;
        endcase
    end

    always_comb begin
        limit = G_LIM;
        succ  = ST_YELLOW;
        case (state_q)
            ST_GREEN:  begin limit = G_LIM; succ = ST_YELLOW; end
            ST_YELLOW: begin limit = Y_LIM; succ = ST_RED;    end
            ST_RED:    begin limit = R_LIM; succ = ST_GREEN;  end
            default:   begin limit = G_LIM; succ = ST_YELLOW; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        seq_ev     = EV_NONE;
        prev_red_d = (pat_st == ST_RED);

        if (state_q == ST_SYNC) begin
            if (pat_st == ST_GREEN && prev_red_q) begin
                state_d = ST_GREEN;
                dwell_d = DW'(1);
            end
        end else if (pat_st == ST_SYNC) begin
            seq_ev = EV_ILLEGAL;
        end else if (pat_st == state_q) begin
            if (dwell_q == limit) seq_ev = EV_LATE;
            else                  dwell_d = dwell_q + DW'(1);
        end else if (pat_st == succ) begin
            if (dwell_q < limit) begin
                seq_ev = EV_EARLY;
            end else begin
                state_d = succ;
                dwell_d = DW'(1);
            end
        end else begin
            seq_ev = EV_BAD_ORDER;
        end

        if (seq_ev != EV_NONE) state_d = ST_SYNC;

        red_run = (state_q != ST_SYNC) && (pat_st == ST_RED) && car_cross;
        new_ev  = (seq_ev != EV_NONE) ? seq_ev : (red_run ? EV_RED_RUN : EV_NONE);

        rr_d = (red_run && rr_q != '1) ? rr_q + CNT_W'(1) : rr_q;
        se_d = (seq_ev != EV_NONE && se_q != '1) ? se_q + CNT_W'(1) : se_q;

        // A pending event is only overwritten when the consumer acks on the same edge.
        valid_d = valid_q;
        code_d  = code_q;
        if (new_ev != EV_NONE && (!valid_q || viol_ack)) begin
            valid_d = 1'b1;
            code_d  = new_ev;
        end else if (viol_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_1) begin
        if (reset) begin
            state_q    <= ST_SYNC;
            dwell_q    <= '0;
            prev_red_q <= 1'b0;
            rr_q       <= '0;
            se_q       <= '0;
            valid_q    <= 1'b0;
            code_q     <= EV_NONE;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            prev_red_q <= prev_red_d;
            rr_q       <= rr_d;
            se_q       <= se_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
        end
    end

`ifdef VIOL_TIMESTAMP_EN
    logic [15:0] tick_q, tick_d;
    logic [15:0] time_q, time_d;

    always_comb begin
        tick_d = tick_q + 16'd1;
        time_d = time_q;
        if (new_ev != EV_NONE && (!valid_q || viol_ack)) time_d = tick_d;
    end

    always_ff @(posedge clk_1) begin
        if (reset) begin
            tick_q <= '0;
            time_q <= '0;
        end else begin
            tick_q <= tick_d;
            time_q <= time_d;
        end
    end

    assign viol_time = time_q;
`endif

    assign viol_valid  = valid_q;
    assign viol_code   = code_q;
    assign red_run_cnt = rr_q;
    assign seq_err_cnt = se_q;
    assign phase       = state_q;
    assign locked      = (state_q != ST_SYNC);

endmodule
